dmem_seq_ctrl: RTL and testbench

- Multi-cycle data-memory access sequencer between the core's load/store request port and the word-wide data bus/RAM.
- Feeds the combinational load/store alignment stage. It latches the fetched word, presents it on al_rdata, and consumes that stage's merged store word (al_wdo) and extended load result (al_rdo).
- Sub-word stores use read-modify-write. Word stores write directly. Loads read, then return one response.

---
 rtl/dmem_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmem_seq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_seq_ctrl.sv
// Data-memory access sequencer: loads, direct word stores and read-modify-write sub-word stores over a word bus.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete at once with rsp_err=1 and never reach the bus.
module dmem_seq_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int BUS_WAIT_MAX = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        al_op,
  output logic              al_we,
  output logic [ADDR_W-1:0] al_adr,
  output logic [31:0]       al_wdin,
  output logic [31:0]       al_rdata,
  input  logic [31:0]       al_wdo,
  input  logic [31:0]       al_rdo,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t            state_r;
  logic [2:0]        op_r;
  logic              we_r;
  logic [ADDR_W-1:0] adr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rbuf_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;
  logic              bus_req_r;
  logic              bus_we_r;
  logic              misalign_s;
  logic              word_store_s;

  // Bus timeout is reserved; a nonzero BUS_WAIT_MAX has no effect in this revision.
  if (BUS_WAIT_MAX != 0) begin : g_wait_reserved
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign_s = ((req_op[1:0] == 2'b01) && req_adr[0]) ||
                      ((req_op[1:0] == 2'b10) && (req_adr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign word_store_s = req_we && (req_op[1:0] == 2'b10);

  // Sequencer FSM with request latches, read buffer and registered bus/response controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      we_r        <= 1'b0;
      adr_r       <= '0;
      wdata_r     <= 32'd0;
      rbuf_r      <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          if (req_valid) begin
            op_r    <= req_op;
            we_r    <= req_we;
            adr_r   <= req_adr;
            wdata_r <= req_wdata;
            if (misalign_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
            end else if (word_store_s) begin
              state_r   <= WR;
              bus_req_r <= 1'b1;
              bus_we_r  <= 1'b1;
            end else begin
              state_r   <= RD;
              bus_req_r <= 1'b1;
              bus_we_r  <= 1'b0;
            end
          end
        end
        RD: begin
          if (bus_ack) begin
            rbuf_r <= bus_rdata;
            if (we_r) begin
              // Sub-word store: merge happens downstream once rbuf holds the old word.
              state_r  <= WR;
              bus_we_r <= 1'b1;
            end else begin
              state_r     <= RESP;
              bus_req_r   <= 1'b0;
              rsp_valid_r <= 1'b1;
            end
          end
        end
        WR: begin
          if (bus_ack) begin
            state_r     <= RESP;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
          end
        end
        RESP: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          bus_req_r   <= 1'b0;
          bus_we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  // al_rdo is derived from rbuf and the latched request, so it is settled throughout RESP.
  assign rsp_rdata = (rsp_valid_r && !we_r && !rsp_err_r) ? al_rdo : 32'd0;

  assign al_op     = op_r;
  assign al_we     = we_r;
  assign al_adr    = adr_r;
  assign al_wdin   = wdata_r;
  assign al_rdata  = rbuf_r;

  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = {adr_r[ADDR_W-1:2], 2'b00};
  assign bus_wdata = bus_we_r ? al_wdo : 32'd0;

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Scoreboard bench for dmem_seq_ctrl: random bus waits, alignment-stage model, transaction-level reference memory.
module tb_dmem_seq_ctrl;
  localparam int ADDR_W = 32;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_adr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  al_op;
  logic        al_we;
  logic [31:0] al_adr, al_wdin, al_rdata, al_wdo, al_rdo;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  dmem_seq_ctrl #(.ADDR_W(ADDR_W), .BUS_WAIT_MAX(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .al_op(al_op), .al_we(al_we), .al_adr(al_adr), .al_wdin(al_wdin), .al_rdata(al_rdata),
    .al_wdo(al_wdo), .al_rdo(al_rdo),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc_cyc;
    int          nph;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk = 0, n_fail = 0;
  int unsigned cyc = 0;
  logic [31:0] mem_dut [int unsigned];
  logic [31:0] mem_ref [int unsigned];
  int          rd_cnt = 0, wr_cnt = 0, wait_sum = 0, stable_bad = 0;
  int          fixed_wait = -1, wait_left = 0;
  bit          hold_ack = 0;
  logic        prev_req = 0, prev_ack = 0, ph_we = 0;
  logic [31:0] ph_addr = 0, ph_wdata = 0;
  logic [31:0] last_addr = 0, last_rdata = 0;
  logic        last_err = 0;
  logic [7:0]  b8;
  logic [15:0] h16;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int unsigned idx);
    return (idx * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] rd_dut(input int unsigned idx);
    return mem_dut.exists(idx) ? mem_dut[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] rd_ref(input int unsigned idx);
    return mem_ref.exists(idx) ? mem_ref[idx] : init_word(idx);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Combinational load/store alignment stage that sits beside the controller.
  always_comb begin
    b8 = 8'd0;
    h16 = 16'd0;
    al_rdo = al_rdata;
    al_wdo = al_wdin;
    case (al_op[1:0])
      2'b00: begin
        b8 = al_rdata[8*al_adr[1:0] +: 8];
        al_rdo = al_op[2] ? {24'd0, b8} : {{24{b8[7]}}, b8};
        al_wdo = al_rdata;
        al_wdo[8*al_adr[1:0] +: 8] = al_wdin[7:0];
      end
      2'b01: begin
        h16 = al_adr[1] ? al_rdata[31:16] : al_rdata[15:0];
        al_rdo = al_op[2] ? {16'd0, h16} : {{16{h16[15]}}, h16};
        al_wdo = al_rdata;
        if (al_adr[1]) al_wdo[31:16] = al_wdin[15:0];
        else           al_wdo[15:0]  = al_wdin[15:0];
      end
      default: begin
        al_rdo = al_rdata;
        al_wdo = al_wdin;
      end
    endcase
  end

  // Reference: whole access computed from the memory word with shifts and masks.
  function automatic exp_t ref_model(input logic we, input logic [2:0] op,
                                     input logic [31:0] adr, input logic [31:0] wd);
    exp_t e;
    int unsigned idx = adr >> 2;
    logic [31:0] w, mask, val;
    int sh, width;
    logic mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = ((op[1:0] == 2'b01) && adr[0]) || ((op[1:0] == 2'b10) && (adr[1:0] != 2'b00));
`endif
    w = rd_ref(idx);
    e.rdata = 32'd0; e.err = mis; e.waddr = adr & 32'hFFFF_FFFC;
    e.nrd = 0; e.nwr = 0; e.nph = 0; e.acc_cyc = 0;
    if (mis) return e;
    if (op[1:0] == 2'b10)      begin sh = 0;            width = 32; mask = 32'hFFFF_FFFF; end
    else if (op[1:0] == 2'b01) begin sh = adr[1] ? 16 : 0; width = 16; mask = 32'h0000_FFFF << sh; end
    else                       begin sh = 8 * adr[1:0];  width = 8;  mask = 32'h0000_00FF << sh; end
    if (!we) begin
      val = (w & mask) >> sh;
      if (!op[2] && width < 32 && val[width-1]) val = val | ~(mask >> sh);
      e.rdata = val; e.nrd = 1; e.nph = 1;
    end else begin
      mem_ref[idx] = (w & ~mask) | ((wd << sh) & mask);
      e.nwr = 1;
      e.nrd = (op[1:0] == 2'b10) ? 0 : 1;
      e.nph = 1 + e.nrd;
    end
    return e;
  endfunction

  // Bus/RAM responder: random waits, stability tracking, stray acks while idle.
  always @(negedge clk) begin
    if (bus_req && rst_n) begin
      if (!prev_req || prev_ack) begin
        wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
        ph_addr = bus_addr; ph_wdata = bus_wdata; ph_we = bus_we;
      end else if (bus_addr !== ph_addr || bus_we !== ph_we || (ph_we && bus_wdata !== ph_wdata)) begin
        stable_bad++;
      end
      if (hold_ack) begin
        bus_ack = 1'b0;
      end else if (wait_left == 0) begin
        bus_ack = 1'b1;
        last_addr = bus_addr;
        if (bus_we) begin
          mem_dut[bus_addr >> 2] = bus_wdata;
          wr_cnt++;
          bus_rdata = $urandom;
        end else begin
          bus_rdata = rd_dut(bus_addr >> 2);
          rd_cnt++;
        end
      end else begin
        bus_ack = 1'b0;
        wait_left--;
        wait_sum++;
        bus_rdata = $urandom;
      end
    end else begin
      bus_ack = ($urandom_range(0, 7) == 0);
      bus_rdata = $urandom;
    end
    prev_req = bus_req;
    prev_ack = bus_ack;
  end

  // Monitor: pop the expected response whenever rsp_valid is seen.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        chk("latency", cyc - mon_e.acc_cyc, mon_e.nph + wait_sum + 1);
        chk("bus_reads", rd_cnt, mon_e.nrd);
        chk("bus_writes", wr_cnt, mon_e.nwr);
        chk("bus_stable", stable_bad, 0);
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (mon_e.nph > 0) chk("bus_addr", last_addr, mon_e.waddr);
      end
      last_rdata = rsp_rdata;
      last_err = rsp_err;
      rd_cnt = 0; wr_cnt = 0; wait_sum = 0; stable_bad = 0;
    end
  end

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] adr, input logic [31:0] wd);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_op = op; req_adr = adr; req_wdata = wd;
    @(posedge clk);
    e = ref_model(we, op, adr, wd);
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_op = 3'($urandom);
    req_adr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] adr;
    int          mem_bad;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_adr = 32'd0; req_wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_al_adr", al_adr, 32'd0);
    chk("rst_al_wdin", al_wdin, 32'd0);
    chk("rst_al_rdata", al_rdata, 32'd0);
    chk("rst_al_opwe", {28'd0, al_op, al_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    fixed_wait = 0;
    mem_dut[32'h40] = 32'hDEADBEEF; mem_ref[32'h40] = 32'hDEADBEEF;
    issue(1'b0, 3'b010, 32'h100, 32'd0);
    drain();
    chk("word_load_val", last_rdata, 32'hDEADBEEF);

    mem_dut[32'h40] = 32'h80112233; mem_ref[32'h40] = 32'h80112233;
    issue(1'b0, 3'b000, 32'h103, 32'd0);
    drain();
    chk("byte_load_signed", last_rdata, 32'hFFFFFF80);
    issue(1'b0, 3'b100, 32'h103, 32'd0);
    drain();
    chk("byte_load_zext", last_rdata, 32'h00000080);

    mem_dut[32'h80] = 32'h11223344; mem_ref[32'h80] = 32'h11223344;
    issue(1'b1, 3'b000, 32'h201, 32'h000000AA);
    drain();
    chk("byte_store_mem", rd_dut(32'h80), 32'h1122AA44);

    fixed_wait = 3;
    issue(1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
    drain();
    chk("word_store_mem", rd_dut(32'hC0), 32'hCAFEF00D);

    fixed_wait = 0;
    issue(1'b0, 3'b001, 32'h401, 32'd0);
    drain();
`ifdef MISALIGN_TRAP_EN
    chk("misalign_err", {31'd0, last_err}, 32'd1);
    chk("misalign_rdata", last_rdata, 32'd0);
`else
    chk("half_noerr", {31'd0, last_err}, 32'd0);
`endif

    hold_ack = 1'b1;
    issue(1'b0, 3'b010, 32'h104, 32'd0);
    repeat (2) @(negedge clk);
    chk("rd_pending", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drops_req", {31'd0, bus_req}, 32'd0);
    chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    sb_q.delete();
    rd_cnt = 0; wr_cnt = 0; wait_sum = 0; stable_bad = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_ack = 1'b0;
    #1;
    chk("ready_after_midrst", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h104, 32'd0);
    drain();

    fixed_wait = -1;
    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom_range(0, 2));
      adr = 32'($urandom_range(0, 32'h3FF));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), {1'($urandom), sz}, adr, $urandom);
    end
    drain();

    mem_bad = 0;
    for (int i = 0; i <= 32'h100; i++) begin
      if (rd_dut(i) !== rd_ref(i)) begin
        if (mem_bad == 0) $display("FAIL mem_word %0d: got %h expected %h", i, rd_dut(i), rd_ref(i));
        mem_bad++;
      end
    end
    chk("mem_final_bad_words", mem_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
